// File: rtl/vnorm_pkg.sv
// vnorm_pkg: shared types and constants for vec_normalize.
// Build option: define VNORM_ROUND_EN to add a round quotient bit
// (round half away from zero) instead of truncating toward zero.
package vnorm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StDiv,
    StStore,
    StReady
  } state_e;

  localparam int unsigned NUM_ELEM  = 4;
  localparam int unsigned ELEM_W    = 32;
  localparam int unsigned FRAC_BITS = 16;
  // Width of |e| << FRAC_BITS fed to the divider.
  localparam int unsigned DVD_W     = ELEM_W + FRAC_BITS;

`ifdef VNORM_ROUND_EN
  // One extra quotient bit below the LSB serves as the round bit.
  localparam int unsigned DIV_ITERS = DVD_W + 1;
`else
  localparam int unsigned DIV_ITERS = DVD_W;
`endif

  localparam logic [ELEM_W-1:0] SAT_POS = 32'h7FFF_FFFF;
  // Symmetric negative limit: -SAT_POS, not the most negative code.
  localparam logic [ELEM_W-1:0] SAT_NEG = 32'h8000_0001;

endpackage

// File: rtl/serial_div.sv
// serial_div: unsigned restoring divider, one quotient bit per cycle.
// When ITERS exceeds DVD_W the dividend is padded with zero LSBs, so the
// extra quotient bits are fractional bits below the integer quotient.
module serial_div #(
  parameter int unsigned DVD_W = 48,
  parameter int unsigned DVS_W = 32,
  parameter int unsigned ITERS = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [ITERS-1:0] quotient,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(ITERS + 1);

  logic [ITERS-1:0] dvd_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVS_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DVS_W:0]   trial;
  logic [DVS_W-1:0] diff;
  logic             ge;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    trial = {rem_q, dvd_q[ITERS-1]};
    ge    = (trial >= {1'b0, dvs_q});
    // When ge holds the difference is below the divisor, so it fits DVS_W bits.
    diff  = trial[DVS_W-1:0] - dvs_q;
  end

  // Asserted during the last iteration so the caller can advance on that edge.
  assign done = (cnt_q == CNT_W'(1));

  // Iteration registers: load on start, then shift one bit per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      quotient <= '0;
    end else if (start) begin
      dvd_q    <= ITERS'(dividend) << (ITERS - DVD_W);
      dvs_q    <= divisor;
      rem_q    <= '0;
      cnt_q    <= CNT_W'(ITERS);
      quotient <= '0;
    end else if (cnt_q != '0) begin
      dvd_q    <= dvd_q << 1;
      rem_q    <= ge ? diff : trial[DVS_W-1:0];
      quotient <= {quotient[ITERS-2:0], ge};
      cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/vec_normalize.sv
// vec_normalize: scales a 4-element signed Q16.16 vector by 1/norm using a
// single shared serial divider, one element at a time.
// Build option: VNORM_ROUND_EN selects round-half-away-from-zero.
module vec_normalize
  import vnorm_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] vector,
  input  logic [31:0]  norm,
  input  logic         enable,
  input  logic         accept_in,
  output logic         accept_out,
  output logic         ready_out,
  output logic [127:0] res,
  output logic         zero_norm
);

  state_e                state_q, state_d;
  logic [127:0]          vec_q;
  logic [ELEM_W-1:0]     norm_q;
  logic [1:0]            k_q;
  logic                  sign_q;
  logic [ELEM_W-1:0]     elem;
  logic [ELEM_W-1:0]     elem_abs;
  logic [DVD_W-1:0]      dividend;
  logic                  div_start;
  logic                  div_done;
  logic [DIV_ITERS-1:0]  quot;
  logic [DVD_W-1:0]      mag;
  logic [ELEM_W-1:0]     elem_res;

  assign div_start  = (state_q == StStart);
  assign accept_out = (state_q == StIdle);
  assign ready_out  = (state_q == StReady);

  serial_div #(
    .DVD_W (DVD_W),
    .DVS_W (ELEM_W),
    .ITERS (DIV_ITERS)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (norm_q),
    .quotient (quot),
    .done     (div_done)
  );

  // Element select, magnitude, rounding, saturation and sign restore.
  always_comb begin
    case (k_q)
      2'd0:    elem = vec_q[127:96];
      2'd1:    elem = vec_q[95:64];
      2'd2:    elem = vec_q[63:32];
      default: elem = vec_q[31:0];
    endcase
    // 0x80000000 maps to magnitude 0x80000000, which is fine as unsigned.
    elem_abs = elem[ELEM_W-1] ? (~elem + 32'd1) : elem;
    dividend = {elem_abs, {FRAC_BITS{1'b0}}};
`ifdef VNORM_ROUND_EN
    mag = quot[DIV_ITERS-1:1] + DVD_W'(quot[0]);
`else
    mag = quot;
`endif
    if (|mag[DVD_W-1:ELEM_W-1]) begin
      elem_res = sign_q ? SAT_NEG : SAT_POS;
    end else begin
      elem_res = {1'b0, mag[ELEM_W-2:0]};
      if (sign_q) begin
        elem_res = ~elem_res + 32'd1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (enable) state_d = (norm == '0) ? StReady : StStart;
      StStart: state_d = StDiv;
      StDiv:   if (div_done) state_d = StStore;
      StStore: state_d = (k_q == 2'(NUM_ELEM - 1)) ? StReady : StStart;
      StReady: if (accept_in) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Job latches, element index, sign and result slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_q     <= '0;
      norm_q    <= '0;
      k_q       <= '0;
      sign_q    <= 1'b0;
      res       <= '0;
      zero_norm <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable) begin
            vec_q     <= vector;
            norm_q    <= norm;
            k_q       <= '0;
            zero_norm <= (norm == '0);
            if (norm == '0) begin
              res <= '0;
            end
          end
        end
        StStart: sign_q <= elem[ELEM_W-1];
        StStore: begin
          case (k_q)
            2'd0:    res[127:96] <= elem_res;
            2'd1:    res[95:64]  <= elem_res;
            2'd2:    res[63:32]  <= elem_res;
            default: res[31:0]   <= elem_res;
          endcase
          if (k_q != 2'(NUM_ELEM - 1)) begin
            k_q <= k_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_normalize.sv
// Directed bench for vec_normalize; expected values hand-computed.
module tb_vec_normalize;

`ifdef VNORM_ROUND_EN
  localparam int LAT = 204;
  localparam logic [127:0] EXP_POS = {32'h0000999A, 32'h0000CCCD, 32'h0, 32'h0};
  localparam logic [127:0] EXP_NEG = {32'hFFFF6666, 32'h0, 32'hFFFF3333, 32'h0};
`else
  localparam int LAT = 200;
  localparam logic [127:0] EXP_POS = {32'h00009999, 32'h0000CCCC, 32'h0, 32'h0};
  localparam logic [127:0] EXP_NEG = {32'hFFFF6667, 32'h0, 32'hFFFF3334, 32'h0};
`endif
  localparam logic [127:0] VEC_POS = {32'h00030000, 32'h00040000, 32'h0, 32'h0};
  localparam logic [127:0] VEC_NEG = {32'hFFFD0000, 32'h0, 32'hFFFC0000, 32'h0};
  localparam logic [127:0] VEC_SAT = {32'h7FFF0000, 32'h80010000, 32'h0, 32'h0};
  localparam logic [127:0] EXP_SAT = {32'h7FFFFFFF, 32'h80000001, 32'h0, 32'h0};
  localparam logic [31:0]  NORM5   = 32'h00050000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] vector = '0;
  logic [31:0]  norm = '0;
  logic         enable = 1'b0;
  logic         accept_in = 1'b0;
  logic         accept_out;
  logic         ready_out;
  logic [127:0] res;
  logic         zero_norm;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vec_normalize dut (
    .clk        (clk),
    .reset      (reset),
    .vector     (vector),
    .norm       (norm),
    .enable     (enable),
    .accept_in  (accept_in),
    .accept_out (accept_out),
    .ready_out  (ready_out),
    .res        (res),
    .zero_norm  (zero_norm)
  );

  // Present a job for one sampling edge, then scramble the inputs.
  task automatic start_job(input logic [127:0] v, input logic [31:0] n);
    @(negedge clk);
    vector = v;
    norm   = n;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    vector = {4{32'hDEADBEEF}};
    norm   = 32'h1234_5678;
  endtask

  // Count sampling points until ready_out, bounded.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (ready_out !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic release_job();
    @(negedge clk);
    accept_in = 1'b1;
    @(negedge clk);
    accept_in = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (accept_out !== 1'b1) begin fails++; $display("FAIL reset_accept_out got %b want 1", accept_out); end
    tests++; if (ready_out !== 1'b0) begin fails++; $display("FAIL reset_ready_out got %b want 0", ready_out); end
    tests++; if (res !== '0) begin fails++; $display("FAIL reset_res got %h want 0", res); end
    tests++; if (zero_norm !== 1'b0) begin fails++; $display("FAIL reset_zero_norm got %b want 0", zero_norm); end
  endtask

  task automatic test_positive();
    int cyc;
    start_job(VEC_POS, NORM5);
    tests++; if (accept_out !== 1'b0) begin fails++; $display("FAIL pos_busy accept_out got %b want 0", accept_out); end
    wait_ready(cyc);
    tests++; if (cyc != LAT) begin fails++; $display("FAIL pos_latency got %0d want %0d", cyc, LAT); end
    tests++; if (res !== EXP_POS) begin fails++; $display("FAIL pos_res got %h want %h", res, EXP_POS); end
    tests++; if (zero_norm !== 1'b0) begin fails++; $display("FAIL pos_zero_norm got %b want 0", zero_norm); end
    tests++; if (accept_out !== 1'b0) begin fails++; $display("FAIL pos_exclusive accept_out got %b want 0", accept_out); end
    release_job();
  endtask

  task automatic test_negative();
    int cyc;
    start_job(VEC_NEG, NORM5);
    wait_ready(cyc);
    tests++; if (cyc != LAT) begin fails++; $display("FAIL neg_latency got %0d want %0d", cyc, LAT); end
    tests++; if (res !== EXP_NEG) begin fails++; $display("FAIL neg_res got %h want %h", res, EXP_NEG); end
    release_job();
  endtask

  task automatic test_zero_norm();
    // res holds the previous nonzero result, so clearing is observable.
    start_job(VEC_POS, 32'h0);
    tests++; if (ready_out !== 1'b1) begin fails++; $display("FAIL zero_latency ready_out got %b want 1", ready_out); end
    tests++; if (res !== '0) begin fails++; $display("FAIL zero_res got %h want 0", res); end
    tests++; if (zero_norm !== 1'b1) begin fails++; $display("FAIL zero_flag got %b want 1", zero_norm); end
    release_job();
  endtask

  task automatic test_saturation();
    int cyc;
    start_job(VEC_SAT, 32'h1);
    wait_ready(cyc);
    tests++; if (cyc != LAT) begin fails++; $display("FAIL sat_latency got %0d want %0d", cyc, LAT); end
    tests++; if (res !== EXP_SAT) begin fails++; $display("FAIL sat_res got %h want %h", res, EXP_SAT); end
    tests++; if (zero_norm !== 1'b0) begin fails++; $display("FAIL sat_zero_norm got %b want 0", zero_norm); end
    release_job();
  endtask

  task automatic test_handshake();
    int cyc;
    int bad;
    start_job(VEC_POS, NORM5);
    repeat (20) @(negedge clk);
    // Stray request while dividing must not restart or corrupt the job.
    enable = 1'b1;
    vector = VEC_NEG;
    norm   = 32'h0;
    @(negedge clk);
    enable = 1'b0;
    wait_ready(cyc);
    tests++; if (cyc + 21 != LAT) begin fails++; $display("FAIL hs_latency got %0d want %0d", cyc + 21, LAT); end
    tests++; if (res !== EXP_POS) begin fails++; $display("FAIL hs_res got %h want %h", res, EXP_POS); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready_out !== 1'b1 || res !== EXP_POS) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL hs_hold unstable samples got %0d want 0", bad); end
    @(negedge clk);
    accept_in = 1'b1;
    @(negedge clk);
    accept_in = 1'b0;
    tests++; if (accept_out !== 1'b1 || ready_out !== 1'b0) begin
      fails++; $display("FAIL hs_to_idle accept/ready got %b%b want 10", accept_out, ready_out);
    end
    tests++; if (res !== EXP_POS) begin fails++; $display("FAIL hs_res_after got %h want %h", res, EXP_POS); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    // Launch immediately from the IDLE cycle left by the previous test.
    vector = VEC_NEG;
    norm   = NORM5;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_ready(cyc);
    tests++; if (cyc != LAT) begin fails++; $display("FAIL b2b_latency got %0d want %0d", cyc, LAT); end
    tests++; if (res !== EXP_NEG) begin fails++; $display("FAIL b2b_res got %h want %h", res, EXP_NEG); end
    release_job();
  endtask

  task automatic test_reset_mid_job();
    int cyc;
    start_job(VEC_POS, NORM5);
    // Element 2 divides between edges 102 and 149 after the sample edge.
    repeat (120) @(negedge clk);
    reset = 1'b1;
    #1;
    tests++; if (accept_out !== 1'b1 || ready_out !== 1'b0) begin
      fails++; $display("FAIL midrst_flags accept/ready got %b%b want 10", accept_out, ready_out);
    end
    tests++; if (res !== '0) begin fails++; $display("FAIL midrst_res got %h want 0", res); end
    tests++; if (zero_norm !== 1'b0) begin fails++; $display("FAIL midrst_zero_norm got %b want 0", zero_norm); end
    @(negedge clk);
    reset = 1'b0;
    start_job(VEC_NEG, NORM5);
    wait_ready(cyc);
    tests++; if (cyc != LAT) begin fails++; $display("FAIL midrst_latency got %0d want %0d", cyc, LAT); end
    tests++; if (res !== EXP_NEG) begin fails++; $display("FAIL midrst_res_after got %h want %h", res, EXP_NEG); end
    release_job();
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_positive();
    test_negative();
    test_zero_norm();
    test_saturation();
    test_handshake();
    test_back_to_back();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
